// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a data
// port. Only one transaction is outstanding at a time. The data port normally
// wins a simultaneous request. A starvation counter lets a waiting fetch win
// once the data port has been granted STARVE_MAX times in a row. A BUSY
// watchdog aborts a transaction that never gets mem_ack and raises a sticky
// err. The aborted requester still receives its ready pulse, with zero data.
//
// Ports
//   clk, rst        sole rising-edge clock, synchronous active-high reset
//   if_req/if_addr  fetch request (held until if_ready) and its address
//   if_ready        one-cycle fetch completion, if_rdata valid with it
//   d_req/d_we      data request (held until d_ready), 1=store 0=load
//   d_addr/d_wdata  data address and store data
//   d_ready         one-cycle data completion, d_rdata valid with it
//   mem_req..wdata  memory request, held stable until mem_ack
//   mem_rdata/ack   memory read data and one-cycle completion
//   err             sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LP_TIMEOUT    = 8'(TIMEOUT);
    localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_starve;
    logic [7:0]      r_busy_cnt;
    logic            r_own_d;       // 1: data port owns the in-flight transaction
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_if_ready;
    logic            r_d_ready;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_err;

    logic            w_req_any;
    logic            w_grant_d;
    logic [7:0]      w_cnt_inc;
    logic            w_timeout;
    logic            w_done;
    logic [DW-1:0]   w_resp_data;

    assign w_req_any   = d_req | if_req;
    // Data wins ties unless fetch has already waited through STARVE_MAX data grants.
    assign w_grant_d   = d_req & ~(if_req & (r_starve == LP_STARVE_MAX));
    assign w_cnt_inc   = r_busy_cnt + 8'd1;
    // This BUSY cycle would be the TIMEOUT-th one without an ack.
    assign w_timeout   = (w_cnt_inc == LP_TIMEOUT);
    assign w_done      = mem_ack | w_timeout;
    // An aborted transaction returns zero data.
    assign w_resp_data = mem_ack ? mem_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_any) w_state_nxt = BUSY;
            BUSY:    if (w_done)    w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_starve    <= 3'd0;
            r_busy_cnt  <= 8'd0;
            r_own_d     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_own_d    <= w_grant_d;
                        r_mem_req  <= 1'b1;
                        r_busy_cnt <= 8'd0;
                        if (w_grant_d) begin
                            r_mem_we    <= d_we;
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= if_addr;
                            r_mem_wdata <= '0;
                        end
                        // Count only data grants that made a waiting fetch wait longer.
                        r_starve <= (w_grant_d && if_req) ? r_starve + 3'd1 : 3'd0;
                    end
                end
                BUSY: begin
                    if (!mem_ack) r_busy_cnt <= w_cnt_inc;
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        if (!mem_ack) r_err <= 1'b1;
                        if (r_own_d) begin
                            r_d_ready <= 1'b1;
                            // A store has nothing to return; d_rdata keeps its value.
                            if (!r_mem_we) r_d_rdata <= w_resp_data;
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= w_resp_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int TIMEOUT    = 255;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          err;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference: what each requester is asking for, what it
    // should last have read back, and how many data grants fetch has sat through.
    bit            m_if_pend = 1'b0;
    bit            m_d_pend  = 1'b0;
    bit            m_d_we    = 1'b0;
    logic [AW-1:0] m_if_addr = '0;
    logic [AW-1:0] m_d_addr  = '0;
    logic [DW-1:0] m_d_wdata = '0;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_d_rdata  = '0;
    int            m_starve  = 0;
    bit            m_err     = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; drive and sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        if_req  = m_if_pend;
        if_addr = m_if_addr;
        d_req   = m_d_pend;
        d_we    = m_d_we;
        d_addr  = m_d_addr;
        d_wdata = m_d_wdata;
    endtask

    // Runs one complete transaction for whichever requester should win.
    // lat = BUSY cycles before mem_ack is presented; obs_f = DUT's if_ready at completion.
    task automatic do_txn(input int lat, input logic [DW-1:0] rd, output bit obs_f);
        bit            win_d;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wdata;
        win_d    = m_d_pend && !(m_if_pend && m_starve == STARVE_MAX);
        m_starve = (win_d && m_if_pend) ? m_starve + 1 : 0;
        e_addr   = win_d ? m_d_addr : m_if_addr;
        e_we     = win_d ? m_d_we : 1'b0;
        e_wdata  = win_d ? m_d_wdata : '0;
        drive_reqs();
        step();
        chk("grant_req", mem_req, 1);
        chk("grant_we", mem_we, e_we);
        chk("grant_addr", mem_addr, e_addr);
        chk("grant_wdata", mem_wdata, e_wdata);
        for (int i = 0; i < lat; i++) begin
            step();
            chk("hold_req", mem_req, 1);
            chk("hold_we", mem_we, e_we);
            chk("hold_addr", mem_addr, e_addr);
            chk("hold_wdata", mem_wdata, e_wdata);
            chk("hold_rdy", {if_ready, d_ready}, 2'b00);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (win_d) begin
            if (!m_d_we) m_d_rdata = rd;
            m_d_pend = 1'b0;
        end else begin
            m_if_rdata = rd;
            m_if_pend  = 1'b0;
        end
        chk("done_mem_req", mem_req, 0);
        chk("done_if_ready", if_ready, !win_d);
        chk("done_d_ready", d_ready, win_d);
        chk("done_if_rdata", if_rdata, m_if_rdata);
        chk("done_d_rdata", d_rdata, m_d_rdata);
        chk("done_err", err, m_err);
        obs_f = if_ready;
        drive_reqs();
        // A stray ack during the response cycle must have no effect.
        mem_ack = 1'($urandom_range(0, 1));
        step();
        mem_ack = 1'b0;
        chk("resp_end_rdy", {if_ready, d_ready}, 2'b00);
        chk("resp_end_req", mem_req, 0);
    endtask

    initial begin
        bit       obs;
        bit [9:0] pat;
        int       cnt;

        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        drive_reqs();
        repeat (3) step();
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        rst = 1'b0;

        // Fetch-only read.
        m_if_pend = 1'b1; m_if_addr = 32'h100;
        do_txn(2, 32'h2402000A, obs);
        chk("fetch_only_rdata", if_rdata, 32'h2402000A);

        // Simultaneous store and fetch: the store goes first.
        m_d_pend = 1'b1; m_d_we = 1'b1; m_d_addr = 32'h40; m_d_wdata = 32'h55;
        m_if_pend = 1'b1; m_if_addr = 32'h200;
        do_txn(1, 32'hCAFE0001, obs);
        chk("tie_first_is_data", obs, 0);
        do_txn(0, 32'hCAFE0002, obs);
        chk("tie_second_is_fetch", obs, 1);

        // Both ports keep asking: four data grants, then one fetch, repeating.
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            if (!m_d_pend) begin
                m_d_pend = 1'b1; m_d_we = 1'b0; m_d_addr = 32'h1000 + i; m_d_wdata = 32'(i);
            end
            if (!m_if_pend) begin
                m_if_pend = 1'b1; m_if_addr = 32'h2000 + i;
            end
            do_txn(int'($urandom_range(0, 2)), $urandom, obs);
            pat[i] = obs;
        end
        chk("starve_pattern", pat, 10'b1000010000);

        // Randomized traffic.
        for (int it = 0; it < 120; it++) begin
            if (!m_if_pend && $urandom_range(0, 1) == 1) begin
                m_if_pend = 1'b1; m_if_addr = $urandom;
            end
            if (!m_d_pend && $urandom_range(0, 2) != 0) begin
                m_d_pend = 1'b1; m_d_we = 1'($urandom_range(0, 1));
                m_d_addr = $urandom; m_d_wdata = $urandom;
            end
            if (!m_if_pend && !m_d_pend) begin
                drive_reqs();
                mem_ack = 1'($urandom_range(0, 1));
                step();
                mem_ack = 1'b0;
                chk("idle_req", mem_req, 0);
                chk("idle_rdy", {if_ready, d_ready}, 2'b00);
            end else begin
                do_txn(int'($urandom_range(0, 4)), $urandom, obs);
            end
        end
        for (int i = 0; i < 2; i++)
            if (m_if_pend || m_d_pend) do_txn(1, $urandom, obs);

        // Give d_rdata a non-zero value so the abort's zeroing is visible.
        m_d_pend = 1'b1; m_d_we = 1'b0; m_d_addr = 32'h44; m_d_wdata = 32'h0;
        do_txn(0, 32'hDEADBEEF, obs);

        // Memory never acknowledges a load: watchdog abort.
        m_d_pend = 1'b1; m_d_we = 1'b0; m_d_addr = 32'h80; m_d_wdata = 32'h1234;
        m_starve = 0;
        drive_reqs();
        step();
        chk("to_grant", mem_req, 1);
        cnt = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (mem_req) cnt++;
            else break;
        end
        chk("to_busy_cycles", cnt, TIMEOUT);
        chk("to_d_ready", d_ready, 1);
        chk("to_if_ready", if_ready, 0);
        chk("to_d_rdata", d_rdata, 0);
        chk("to_err", err, 1);
        m_d_rdata = '0; m_err = 1'b1; m_d_pend = 1'b0;
        drive_reqs();
        step();
        chk("to_ready_low", d_ready, 0);
        chk("to_err_hold", err, 1);

        // err stays set across later normal traffic.
        m_d_pend = 1'b1; m_d_we = 1'b0; m_d_addr = 32'h48;
        do_txn(1, 32'h0BADF00D, obs);
        chk("err_sticky", err, 1);

        // Reset in the middle of a store.
        m_d_pend = 1'b1; m_d_we = 1'b1; m_d_addr = 32'hC0; m_d_wdata = 32'hA5A5;
        drive_reqs();
        step();
        chk("rb_grant", mem_req, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rb_mem_req", mem_req, 0);
        chk("rb_mem_we", mem_we, 0);
        chk("rb_mem_addr", mem_addr, 0);
        chk("rb_mem_wdata", mem_wdata, 0);
        chk("rb_rdy", {if_ready, d_ready}, 2'b00);
        chk("rb_rdata", {if_rdata, d_rdata}, 0);
        chk("rb_err", err, 0);
        m_d_pend = 1'b0; m_if_rdata = '0; m_d_rdata = '0; m_err = 1'b0; m_starve = 0;
        drive_reqs();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rb_late_ack_rdy", {if_ready, d_ready}, 2'b00);
            chk("rb_late_ack_req", mem_req, 0);
            step();
        end

        // Requester re-presents after reset.
        m_if_pend = 1'b1; m_if_addr = 32'h300;
        do_txn(1, 32'h13579BDF, obs);
        chk("rb_reissue_fetch", obs, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter SHALL be: AW, 32, address width.
REQ-002 Parameter SHALL be: DW, 32, data width.
REQ-003 Parameter SHALL be: TIMEOUT, 255, maximum BUSY cycles without mem_ack before abort.
REQ-004 Parameter SHALL be: STARVE_MAX, 4, maximum consecutive data grants while fetch is pending.
REQ-005 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  AW  fetch address.
- if_ready  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DW  fetch data, valid while if_ready=1.
- d_req  in  1  data request, held until d_ready.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ready  out  1  one-cycle data completion pulse.
- d_rdata  out  DW  load data, valid while d_ready=1.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- err  out  1  sticky timeout flag.

Function
REQ-006 Block SHALL arbitrate one single-port memory between the fetch port and the data port, with one transaction in flight.
REQ-007 FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-008 In IDLE, if d_req or if_req is sampled at edge t, the block SHALL latch the winner's addr/we/wdata, enter BUSY, and drive mem_req=1 with latched values from t+1.
REQ-009 Winner SHALL be data when both requests are high, unless the starve counter equals STARVE_MAX, in which case fetch SHALL win.
REQ-010 Starve counter (3 bits) SHALL increment on each data grant made while if_req=1, clear on any fetch grant, and clear on any grant made while if_req=0.
REQ-011 Fetch grants SHALL drive mem_we=0 and mem_wdata=0.
REQ-012 mem_req, mem_we, mem_addr, and mem_wdata SHALL be stable throughout BUSY.
REQ-013 When mem_ack=1 in BUSY, the block SHALL capture mem_rdata into the winner's rdata register, deassert mem_req, and enter RESP.
REQ-014 Completion latency SHALL be: mem_ack at edge t+k gives the matching ready=1 in cycle t+k+1.
REQ-015 A store SHALL leave d_rdata unchanged.
REQ-016 In RESP, the block SHALL pulse exactly one ready for one cycle, accept no new request, and return to IDLE.
REQ-017 Back-to-back throughput SHALL be at most one transaction per (k+2) cycles.
REQ-018 A BUSY cycle counter (8 bits) SHALL clear on entry to BUSY and increment on each BUSY cycle without mem_ack.
REQ-019 When the BUSY counter reaches TIMEOUT, the block SHALL deassert mem_req, set err=1, load rdata=0, and go to RESP so the requester still receives ready.
REQ-020 err SHALL remain 1 until rst.
REQ-021 mem_ack seen in IDLE or RESP SHALL be ignored.
REQ-022 if_ready and d_ready SHALL never be high in the same cycle.

Reset
REQ-023 On rst=1 at an edge, the FSM SHALL go to IDLE and clear all counters.
REQ-024 On the same reset edge, if_ready, d_ready, mem_req, mem_we, and err SHALL be 0.
REQ-025 On the same reset edge, mem_addr, mem_wdata, if_rdata, and d_rdata SHALL be 0.
REQ-026 A reset during BUSY or RESP SHALL discard the in-flight transaction with no ready pulse.
REQ-027 A requester SHALL re-present its request after reset deasserts.

Verification
REQ-028 Scenario: fetch only, if_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0x2402000A -> if_ready=1 one cycle after ack, if_rdata=0x2402000A, mem_we=0.
REQ-029 Scenario: d_req(we=1, addr=0x40, wdata=0x55) and if_req in the same cycle -> data granted first with mem_we=1, mem_addr=0x40, mem_wdata=0x55, then fetch is granted after d_ready.
REQ-030 Scenario: d_req held continuously with if_req pending -> exactly 4 data grants, then 1 fetch grant, repeating.
REQ-031 Scenario: mem_ack never asserted -> mem_req drops after 255 BUSY cycles, err=1, d_ready pulses with d_rdata=0, err stays 1.
REQ-032 Scenario: rst pulsed during BUSY -> next cycle all outputs are 0 and the FSM is in IDLE; a late mem_ack produces no ready pulse.
